// File: rtl/vcxo_lock_sequencer.sv
// vcxo_lock_sequencer: measurement sequencer for the VCXO discipline loop.
// It starts frequency measurements and accepts a result only when it repeats
// the previous one. Stable results become saturated PWM correction steps and
// drive the lock / unlock qualification. TX suspends the loop (holdover).
module vcxo_lock_sequencer #(
    parameter int LOCK_TOL      = 1,
    parameter int COARSE_TOL    = 10,
    parameter int LOCK_COUNT    = 4,
    parameter int UNLOCK_COUNT  = 2,
    parameter int STEP_MAX      = 4096,
    parameter int MEAS_TIMEOUT  = 1300000,
    parameter int SETTLE_CYCLES = 16
) (
    input  logic        clk_in,
    input  logic        reset_in,
    input  logic        enable_in,
    input  logic        tx_in,
    input  logic        meas_done_in,
    input  logic [31:0] freq_error_in,
    output logic        meas_start,
    output logic        meas_abort,
    output logic        pwm_update,
    output logic [31:0] pwm_step,
    output logic        locked,
    output logic        timeout_flag,
    output logic [31:0] last_error
);

    localparam int CNT_MAX = (MEAS_TIMEOUT > SETTLE_CYCLES) ? MEAS_TIMEOUT : SETTLE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(MEAS_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [7:0]        LOCK_N       = 8'(LOCK_COUNT);
    localparam logic [7:0]        UNLOCK_N     = 8'(UNLOCK_COUNT);
    localparam logic [32:0]       LOCK_TOL_33  = 33'(LOCK_TOL);
    localparam logic [32:0]       COARSE_TOL_33 = 33'(COARSE_TOL);
    localparam logic signed [33:0] STEP_POS    = 34'(STEP_MAX);
    localparam logic signed [33:0] STEP_NEG    = -34'(STEP_MAX);

    typedef enum logic [2:0] {
        IDLE,
        HOLD,
        SETTLE,
        START,
        WAIT_MEAS,
        EVAL
    } state_t;

    state_t state;
    state_t next_state;

    logic [CNT_W-1:0]   cnt;
    logic signed [31:0] cap_error;
    logic signed [31:0] prev_error;
    logic               prev_valid;
    logic [7:0]         lock_cnt;
    logic [7:0]         unlock_cnt;

    logic               settle_done;
    logic               timeout_hit;
    logic               stable;
    logic               do_eval;
    logic signed [32:0] e33;
    logic [32:0]        mag;
    logic               is_fine;
    logic               is_coarse;
    logic signed [33:0] e34;
    logic signed [33:0] step_raw;
    logic [31:0]        step_sat;
    logic [7:0]         lock_inc;
    logic [7:0]         unlock_inc;

    // Next-state selection: TX beats disable, which beats the normal flow.
    always_comb begin
        next_state  = state;
        settle_done = (cnt == SETTLE_LAST);
        timeout_hit = (state == WAIT_MEAS) && !meas_done_in && (cnt == TIMEOUT_LAST);
        if (tx_in) begin
            next_state = HOLD;
        end else if (!enable_in) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:      next_state = SETTLE;
                HOLD:      next_state = SETTLE;
                SETTLE:    if (settle_done) next_state = START;
                START:     next_state = WAIT_MEAS;
                WAIT_MEAS: begin
                    if (meas_done_in)     next_state = EVAL;
                    else if (timeout_hit) next_state = SETTLE;
                end
                EVAL:      next_state = START;
                default:   next_state = SETTLE;
            endcase
        end
    end

    // Result evaluation: stability test, error magnitude class and saturated step.
    always_comb begin
        stable   = prev_valid && (cap_error == prev_error);
        do_eval  = (state == EVAL) && (next_state == START);
        e33      = {cap_error[31], cap_error};
        mag      = e33[32] ? 33'(-e33) : 33'(e33);
        is_fine  = (mag <= LOCK_TOL_33);
        is_coarse = (mag > COARSE_TOL_33);
        e34      = {{2{cap_error[31]}}, cap_error};
        step_raw = '0;
        if (is_coarse)     step_raw = -(e34 <<< 1);
        else if (!is_fine) step_raw = -e34;
        if (step_raw > STEP_POS)      step_sat = 32'(STEP_POS);
        else if (step_raw < STEP_NEG) step_sat = 32'(STEP_NEG);
        else                          step_sat = step_raw[31:0];
        lock_inc   = (lock_cnt == LOCK_N) ? lock_cnt : lock_cnt + 8'd1;
        unlock_inc = (unlock_cnt == UNLOCK_N) ? unlock_cnt : unlock_cnt + 8'd1;
    end

    // State register.
    always_ff @(posedge clk_in) begin
        if (reset_in) state <= SETTLE;
        else          state <= next_state;
    end

    // Counters, captured errors, status and registered output strobes.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            cnt          <= '0;
            cap_error    <= '0;
            prev_error   <= '0;
            prev_valid   <= 1'b0;
            lock_cnt     <= '0;
            unlock_cnt   <= '0;
            meas_start   <= 1'b0;
            meas_abort   <= 1'b0;
            pwm_update   <= 1'b0;
            pwm_step     <= '0;
            locked       <= 1'b0;
            timeout_flag <= 1'b0;
            last_error   <= '0;
        end else begin
            meas_start <= (next_state == START);
            meas_abort <= ((next_state == HOLD) || (next_state == IDLE)) &&
                          ((state == START) || (state == WAIT_MEAS) ||
                           (state == EVAL) || (state == SETTLE));
            pwm_update <= do_eval && stable;

            if (next_state != state)
                cnt <= '0;
            else if ((state == SETTLE) || (state == WAIT_MEAS))
                cnt <= cnt + CNT_W'(1);

            if ((state == WAIT_MEAS) && (next_state == EVAL))
                cap_error <= freq_error_in;

            if (timeout_hit && (next_state == SETTLE)) begin
                timeout_flag <= 1'b1;
                locked       <= 1'b0;
                prev_valid   <= 1'b0;
            end

            if (next_state == HOLD)
                prev_valid <= 1'b0;

            if ((next_state == IDLE) && (state != IDLE))
                locked <= 1'b0;

            if (do_eval) begin
                prev_error <= cap_error;
                prev_valid <= 1'b1;
                if (stable) begin
                    last_error <= cap_error;
                    pwm_step   <= step_sat;
                    if (is_fine) begin
                        lock_cnt   <= lock_inc;
                        unlock_cnt <= '0;
                        if (lock_inc == LOCK_N) locked <= 1'b1;
                    end else if (is_coarse) begin
                        unlock_cnt <= unlock_inc;
                        lock_cnt   <= '0;
                        if (locked && (unlock_inc == UNLOCK_N)) locked <= 1'b0;
                    end else begin
                        lock_cnt   <= '0;
                        unlock_cnt <= '0;
                    end
                end
            end
        end
    end

endmodule
